// File: rtl/qmult_pkg.sv
// Shared definitions for the sequential sign-magnitude Q-format multiplier.
//   state_t         : controller state encoding (IDLE/MUL/FIN/DONE)
//   ROUND_*         : values accepted by the ROUND parameter
//   cnt_width()     : width of the shift-add step counter, clog2(N-1)
package qmult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FIN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned ROUND_TRUNC   = 0;
  localparam int unsigned ROUND_HALF_UP = 1;

  // Counter must hold 0 .. N-2 (N-1 shift-add steps).
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n - 1);
  endfunction

endpackage

// File: rtl/qmult_seq.sv
// Sequential sign-magnitude fixed-point multiplier (shift-add, one adder).
// Ports:
//   i_clk, i_rst_n              : clock, synchronous active-low reset
//   i_valid / o_ready           : operand handshake (i_multiplicand, i_multiplier)
//   o_valid / i_ready           : result handshake (o_result, o_ovr)
//   o_ovr_sticky, i_clr_ovr     : accumulated overflow flag and its clear
// Accept at edge 0, result valid after edge N; no overlap between operations.
module qmult_seq
  import qmult_pkg::*;
#(
  parameter int unsigned Q        = 15,
  parameter int unsigned N        = 32,
  parameter int unsigned ROUND    = ROUND_TRUNC,
  parameter int unsigned SATURATE = 0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_multiplicand,
  input  logic [N-1:0] i_multiplier,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_result,
  output logic         o_ovr,
  output logic         o_ovr_sticky,
  input  logic         i_clr_ovr
);

  localparam int unsigned MW = N - 1;          // magnitude width
  localparam int unsigned PW = 2 * N - 2;      // exact product width
  localparam int unsigned CW = cnt_width(N);   // step counter width

  // Reject illegal geometry at elaboration.
  if (N < 4) begin : g_bad_n
    $error("qmult_seq: N must be at least 4");
  end
  if ((Q < 1) || (Q > N - 2)) begin : g_bad_q
    $error("qmult_seq: Q must satisfy 1 <= Q <= N-2");
  end

  state_t          state_q;
  state_t          state_nxt;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   mcand_q;
  logic [MW-1:0]   mplier_q;
  logic            sign_q;

  logic            load_c;
  logic            step_c;
  logic            fin_c;
  logic            last_step_c;

  logic            rnd_bit_c;
  logic [N-1:0]    round_sum_c;
  logic            hi_nz_c;
  logic            ovr_c;
  logic [MW-1:0]   mag_c;
  logic            sign_c;
  logic            acc_unused_c;

  assign last_step_c = (cnt_q == CW'(N - 2));

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: if (i_valid)     state_nxt = ST_MUL;
      ST_MUL:  if (last_step_c) state_nxt = ST_FIN;
      ST_FIN:                   state_nxt = ST_DONE;
      ST_DONE: if (i_ready)     state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  // Datapath control strobes decoded from the current state.
  always_comb begin
    load_c = 1'b0;
    step_c = 1'b0;
    fin_c  = 1'b0;
    case (state_q)
      ST_IDLE: load_c = i_valid;
      ST_MUL:  step_c = 1'b1;
      ST_FIN:  fin_c  = 1'b1;
      default: ;
    endcase
  end

  // Finaliser: scale the exact product back to Q format, round, detect overflow.
  assign rnd_bit_c    = (ROUND == ROUND_HALF_UP) ? acc_q[Q-1] : 1'b0;
  assign round_sum_c  = {1'b0, acc_q[N-2+Q:Q]} + N'(rnd_bit_c);
  assign hi_nz_c      = |acc_q[PW-1:N-1+Q];
  assign ovr_c        = hi_nz_c | round_sum_c[N-1];
  assign mag_c        = (ovr_c && (SATURATE != 0)) ? {MW{1'b1}} : round_sum_c[MW-1:0];
  assign sign_c       = sign_q & (|mag_c);   // no negative zero
  // Product bits below the rounding position are intentionally discarded.
  assign acc_unused_c = ^acc_q;

  // Shift-add core: multiplicand shifts left, multiplier shifts right.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
    end else if (load_c) begin
      acc_q    <= '0;
      mcand_q  <= PW'(i_multiplicand[MW-1:0]);
      mplier_q <= i_multiplier[MW-1:0];
      sign_q   <= i_multiplicand[N-1] ^ i_multiplier[N-1];
      cnt_q    <= '0;
    end else if (step_c) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
    end
  end

  // Registered result and flags.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_result     <= '0;
      o_ovr        <= 1'b0;
      o_ovr_sticky <= 1'b0;
    end else begin
      if (fin_c) begin
        o_result <= {sign_c, mag_c};
        o_ovr    <= ovr_c;
      end
      // A new overflow wins over a simultaneous clear.
      if (fin_c && ovr_c) begin
        o_ovr_sticky <= 1'b1;
      end else if (i_clr_ovr) begin
        o_ovr_sticky <= 1'b0;
      end
    end
  end

  // Handshake flags registered from the next state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_ready <= 1'b1;
      o_valid <= 1'b0;
    end else begin
      o_ready <= (state_nxt == ST_IDLE);
      o_valid <= (state_nxt == ST_DONE);
    end
  end

endmodule

// File: tb/tb_qmult_seq.sv
// Directed self-checking bench for qmult_seq (N=32, Q=15).
// d0: truncate + wrap, d1: round + saturate, both driven with the same stimulus.
module tb_qmult_seq;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        i_ready;
  logic        i_clr_ovr;
  logic [31:0] i_multiplicand;
  logic [31:0] i_multiplier;

  logic        d0_ready, d0_valid, d0_ovr, d0_sticky;
  logic        d1_ready, d1_valid, d1_ovr, d1_sticky;
  logic [31:0] d0_result, d1_result;

  int n_vec = 0;
  int n_bad = 0;

  // Expected values for the operation currently in flight.
  logic [31:0] exp_res0, exp_res1;
  logic        exp_ovr0, exp_ovr1;
  logic        exp_stk0 = 1'b0;
  logic        exp_stk1 = 1'b0;

  int busy = 0;
  int last_busy = 0;

  always #5 i_clk = ~i_clk;

  qmult_seq #(.Q(15), .N(32), .ROUND(0), .SATURATE(0)) dut0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(d0_ready),
    .i_multiplicand(i_multiplicand), .i_multiplier(i_multiplier),
    .o_valid(d0_valid), .i_ready(i_ready), .o_result(d0_result),
    .o_ovr(d0_ovr), .o_ovr_sticky(d0_sticky), .i_clr_ovr(i_clr_ovr)
  );

  qmult_seq #(.Q(15), .N(32), .ROUND(1), .SATURATE(1)) dut1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(d1_ready),
    .i_multiplicand(i_multiplicand), .i_multiplier(i_multiplier),
    .o_valid(d1_valid), .i_ready(i_ready), .o_result(d1_result),
    .o_ovr(d1_ovr), .o_ovr_sticky(d1_sticky), .i_clr_ovr(i_clr_ovr)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: exact integer product, rescaled by 2^-15, optional half-up round.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input bit rnd, input bit sat,
                                output logic [31:0] res, output logic ovr);
    longint unsigned ma, mb, p, s;
    logic [30:0] mag;
    ma = 64'(a[30:0]);
    mb = 64'(b[30:0]);
    p  = ma * mb;
    s  = p / 64'd32768;
    if (rnd) s = s + ((p / 64'd16384) % 64'd2);
    ovr = (s >= 64'h8000_0000);
    if (ovr && sat) mag = 31'h7FFF_FFFF;
    else            mag = 31'(s % 64'h8000_0000);
    res = {(a[31] ^ b[31]) && (mag != 31'd0), mag};
  endfunction

  // Every-cycle compare against the model while a result is presented.
  always @(negedge i_clk) begin
    if (i_rst_n === 1'b1) begin
      check("d0_rdy_vld_excl", 32'(d0_ready & d0_valid), 32'd0);
      check("d1_rdy_vld_excl", 32'(d1_ready & d1_valid), 32'd0);
      if (d0_valid) begin
        check("d0_result", d0_result, exp_res0);
        check("d0_ovr", 32'(d0_ovr), 32'(exp_ovr0));
        check("d0_sticky", 32'(d0_sticky), 32'(exp_stk0));
      end
      if (d1_valid) begin
        check("d1_result", d1_result, exp_res1);
        check("d1_ovr", 32'(d1_ovr), 32'(exp_ovr1));
        check("d1_sticky", 32'(d1_sticky), 32'(exp_stk1));
      end
    end
  end

  // Length of the most recent o_ready-low window.
  always @(negedge i_clk) begin
    if (i_rst_n !== 1'b1) begin
      busy = 0;
    end else if (!d0_ready) begin
      busy++;
    end else if (busy != 0) begin
      last_busy = busy;
      busy = 0;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!d0_ready && n < 200) begin
      @(posedge i_clk); #1;
      n++;
    end
    check("ready_timeout", 32'(d0_ready), 32'd1);
  endtask

  // One operation; lit*/lov* are hand-computed expectations that pin the model.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lit0, input logic lov0,
                        input logic [31:0] lit1, input logic lov1,
                        input bit pulse_mid, input bit clr_fin);
    logic [31:0] r0, r1;
    logic o0, o1;
    int cyc;
    model(a, b, 1'b0, 1'b0, r0, o0);
    model(a, b, 1'b1, 1'b1, r1, o1);
    check("model_res0", r0, lit0);
    check("model_ovr0", 32'(o0), 32'(lov0));
    check("model_res1", r1, lit1);
    check("model_ovr1", 32'(o1), 32'(lov1));
    wait_ready();
    exp_res0 = r0; exp_ovr0 = o0;
    exp_res1 = r1; exp_ovr1 = o1;
    exp_stk0 = clr_fin ? o0 : (exp_stk0 | o0);
    exp_stk1 = clr_fin ? o1 : (exp_stk1 | o1);
    i_multiplicand = a;
    i_multiplier   = b;
    i_valid        = 1'b1;
    @(posedge i_clk); #1;
    i_valid        = 1'b0;
    i_multiplicand = $urandom;   // must not disturb the accepted operands
    i_multiplier   = $urandom;
    cyc = 0;
    while (!d0_valid && cyc < 100) begin
      i_valid   = (pulse_mid && cyc == 5);
      i_clr_ovr = (clr_fin && cyc == 31);
      @(posedge i_clk); #1;
      cyc++;
      i_valid   = 1'b0;
      i_clr_ovr = 1'b0;
    end
    check("latency", 32'(cyc), 32'd32);
  endtask

  task automatic clear_sticky();
    i_clr_ovr = 1'b1;
    @(posedge i_clk); #1;
    i_clr_ovr = 1'b0;
    exp_stk0 = 1'b0;
    exp_stk1 = 1'b0;
    check("d0_sticky_cleared", 32'(d0_sticky), 32'd0);
    check("d1_sticky_cleared", 32'(d1_sticky), 32'd0);
  endtask

  task automatic check_busy_window();
    @(posedge i_clk);
    @(negedge i_clk); #1;
    check("busy_window", 32'(last_busy), 32'd33);
  endtask

  initial begin
    logic [31:0] held;
    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_clr_ovr = 1'b0;
    i_multiplicand = '0; i_multiplier = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_ready", 32'({d0_ready, d1_ready}), 32'd3);
    check("rst_valid", 32'({d0_valid, d1_valid}), 32'd0);
    check("rst_result0", d0_result, 32'd0);
    check("rst_result1", d1_result, 32'd0);
    check("rst_flags", 32'({d0_ovr, d1_ovr, d0_sticky, d1_sticky}), 32'd0);
    i_rst_n = 1'b1;

    // Basic and back-to-back with i_ready tied high.
    run_op(32'h0000_C000, 32'h0001_0000, 32'h0001_8000, 1'b0, 32'h0001_8000, 1'b0, 1'b0, 1'b0);
    check_busy_window();
    run_op(32'h8000_C000, 32'h0001_0000, 32'h8001_8000, 1'b0, 32'h8001_8000, 1'b0, 1'b0, 1'b0);
    check_busy_window();
    // Canonical zero.
    run_op(32'h8000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    // Overflow: wrap vs saturate.
    run_op(32'h4000_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0);
    check("d0_sticky_set", 32'(d0_sticky), 32'd1);
    check("d1_sticky_set", 32'(d1_sticky), 32'd1);
    // Sticky survives a clean op, then clears.
    run_op(32'h0000_C000, 32'h0001_0000, 32'h0001_8000, 1'b0, 32'h0001_8000, 1'b0, 1'b0, 1'b0);
    @(posedge i_clk); #1;
    check("d0_sticky_held", 32'(d0_sticky), 32'd1);
    clear_sticky();
    // Rounding.
    run_op(32'h0000_0001, 32'h0000_4000, 32'h0000_0000, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    run_op(32'h8000_0001, 32'h0000_4000, 32'h0000_0000, 1'b0, 32'h8000_0001, 1'b0, 1'b0, 1'b0);
    run_op(32'h7FFF_FFFF, 32'h0000_8000, 32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0);
    // Clear coinciding with a new overflow: set wins.
    run_op(32'h4000_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);
    check("d0_set_wins", 32'(d0_sticky), 32'd1);
    check("d1_set_wins", 32'(d1_sticky), 32'd1);
    @(posedge i_clk); #1;
    clear_sticky();

    // Backpressure with a stray i_valid pulse during MUL.
    i_ready = 1'b0;
    run_op(32'h0000_C000, 32'h0001_0000, 32'h0001_8000, 1'b0, 32'h0001_8000, 1'b0, 1'b1, 1'b0);
    held = d0_result;
    for (int k = 0; k < 10; k++) begin
      @(posedge i_clk); #1;
      check("bp_stable", d0_result, held);
      check("bp_ready_low", 32'({d0_ready, d1_ready}), 32'd0);
      check("bp_valid_high", 32'({d0_valid, d1_valid}), 32'd3);
    end
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    check("bp_release", 32'({d0_ready, d0_valid}), 32'd2);

    // Reset in the middle of MUL.
    run_op(32'h0000_C000, 32'h0001_0000, 32'h0001_8000, 1'b0, 32'h0001_8000, 1'b0, 1'b0, 1'b0);
    wait_ready();
    i_multiplicand = 32'h7FFF_FFFF; i_multiplier = 32'h7FFF_FFFF; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (10) begin @(posedge i_clk); #1; end
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    check("mid_rst_ready", 32'({d0_ready, d1_ready}), 32'd3);
    check("mid_rst_valid", 32'({d0_valid, d1_valid}), 32'd0);
    check("mid_rst_result0", d0_result, 32'd0);
    check("mid_rst_result1", d1_result, 32'd0);
    i_rst_n = 1'b1;
    exp_stk0 = 1'b0;
    exp_stk1 = 1'b0;
    run_op(32'h8000_C000, 32'h0001_0000, 32'h8001_8000, 1'b0, 32'h8001_8000, 1'b0, 1'b0, 1'b0);
    @(posedge i_clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
